ysyx_22050550_ifu: RTL and testbench

Instruction fetch unit that consumes the fetch PC published by the PC register and reads instructions over an AXI4-Lite-style read channel. It returns 32-bit instructions to the ID stage and pulses the PC register's `ready` when an instruction has been handed off. It discards in-flight fetches when ID redirects (jal/jalr/branch/ecall/mret).

---
 rtl/ysyx_22050550_ifu_pkg.sv | 16 +
 rtl/ysyx_22050550_ifu_reg.sv | 19 +
 rtl/ysyx_22050550_ifu.sv | 104 ++++++++++
 tb/tb_ysyx_22050550_ifu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050550_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// register width and the AXI OKAY response code.
package ysyx_22050550_ifu_pkg;

    localparam int REGWIDTH = 64;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_ADDR = 2'd1,
        IFU_DATA = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_t;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_22050550_ifu_reg.sv
// Generic enable register with asynchronous active-high reset to a
// configurable value; used for every piece of IFU state.
module ysyx_22050550_Reg #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= RST_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/ysyx_22050550_ifu.sv
// Instruction fetch unit: one outstanding AXI4-Lite read per instruction,
// hands the selected 32-bit word to ID and tells the PC register to advance.
module ysyx_22050550_ifu
    import ysyx_22050550_ifu_pkg::*;
#(
    parameter int ADDR_W = REGWIDTH,
    parameter int DATA_W = 64,
    parameter int INST_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              redirect_i,
    output logic              pc_ready_o,
    output logic [ADDR_W-1:0] araddr_o,
    output logic              arvalid_o,
    input  logic              arready_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [1:0]        rresp_i,
    input  logic              rvalid_i,
    output logic              rready_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0] if_inst_o,
    output logic              if_fault_o,
    output logic              if_valid_o,
    input  logic              id_ready_i
);

    ifu_state_t        state_q, state_d;
    logic [1:0]        state_bits;
    logic              kill_q, kill_d;
    logic [ADDR_W-1:0] req_pc_q;
    logic              req_pc_en;
    logic              deliver;
    logic              fault_d;
    logic [INST_W-1:0] inst_d;

    assign state_q = ifu_state_t'(state_bits);

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        req_pc_en = 1'b0;
        deliver   = 1'b0;
        case (state_q)
            IFU_IDLE: begin
                // pc_i already carries any redirect target, so just sample it
                req_pc_en = 1'b1;
                state_d   = IFU_ADDR;
            end
            IFU_ADDR: begin
                if (redirect_i) kill_d = 1'b1;
                if (arready_i)  state_d = IFU_DATA;
            end
            IFU_DATA: begin
                if (rvalid_i) begin
                    if (kill_q || redirect_i) begin
                        kill_d  = 1'b0;
                        state_d = IFU_IDLE;
                    end else begin
                        deliver = 1'b1;
                        state_d = IFU_HOLD;
                    end
                end else if (redirect_i) begin
                    kill_d = 1'b1;
                end
            end
            IFU_HOLD: begin
                if (redirect_i || id_ready_i) state_d = IFU_IDLE;
            end
            default: state_d = IFU_IDLE;
        endcase
    end

    assign fault_d = (rresp_i != RRESP_OKAY);
    assign inst_d  = fault_d     ? '0 :
                     req_pc_q[2] ? rdata_i[2*INST_W-1:INST_W] : rdata_i[INST_W-1:0];

    assign arvalid_o  = (state_q == IFU_ADDR);
    assign rready_o   = (state_q == IFU_DATA);
    assign if_valid_o = (state_q == IFU_HOLD);
    assign araddr_o   = {req_pc_q[ADDR_W-1:3], 3'b000};
    // A redirect in HOLD wins: the PC register updates itself in that case
    assign pc_ready_o = if_valid_o & id_ready_i & ~redirect_i;

    ysyx_22050550_Reg #(.WIDTH(2)) u_state (
        .clk(clock), .rst(reset), .en(1'b1), .d(state_d), .q(state_bits));

    ysyx_22050550_Reg #(.WIDTH(1)) u_kill (
        .clk(clock), .rst(reset), .en(1'b1), .d(kill_d), .q(kill_q));

    ysyx_22050550_Reg #(.WIDTH(ADDR_W)) u_req_pc (
        .clk(clock), .rst(reset), .en(req_pc_en), .d(pc_i), .q(req_pc_q));

    ysyx_22050550_Reg #(.WIDTH(ADDR_W)) u_if_pc (
        .clk(clock), .rst(reset), .en(deliver), .d(req_pc_q), .q(if_pc_o));

    ysyx_22050550_Reg #(.WIDTH(INST_W)) u_if_inst (
        .clk(clock), .rst(reset), .en(deliver), .d(inst_d), .q(if_inst_o));

    ysyx_22050550_Reg #(.WIDTH(1)) u_if_fault (
        .clk(clock), .rst(reset), .en(deliver), .d(fault_d), .q(if_fault_o));

endmodule

// File: tb/tb_ysyx_22050550_ifu.sv
// Directed plus randomized bench for the fetch unit, with a small AXI slave
// driven inline and expected values computed from the fetch rules.
module tb_ysyx_22050550_ifu;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] pc_i;
    logic        redirect_i;
    logic        pc_ready_o;
    logic [63:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [63:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [63:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_fault_o;
    logic        if_valid_o;
    logic        id_ready_i;

    int checks = 0;
    int errors = 0;

    ysyx_22050550_ifu dut (
        .clock(clock), .reset(reset), .pc_i(pc_i), .redirect_i(redirect_i),
        .pc_ready_o(pc_ready_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o),
        .arready_i(arready_i), .rdata_i(rdata_i), .rresp_i(rresp_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .if_pc_o(if_pc_o),
        .if_inst_o(if_inst_o), .if_fault_o(if_fault_o), .if_valid_o(if_valid_o),
        .id_ready_i(id_ready_i));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        redirect_i = 1'b0;
        arready_i  = 1'b0;
        rvalid_i   = 1'b0;
        rresp_i    = 2'b00;
        id_ready_i = 1'b0;
        rdata_i    = {$urandom, $urandom};
    endtask

    // Full fetch from IDLE; optionally ends HOLD with redirect+id_ready together.
    task automatic do_fetch(input logic [63:0] pc, input int ar_dly, input int r_dly,
                            input logic [63:0] data, input logic [1:0] resp,
                            input int stall, input bit hold_redirect);
        logic [31:0] exp_inst;
        logic        exp_fault;
        exp_fault = (resp != 2'b00);
        exp_inst  = exp_fault ? 32'h0 : (pc[2] ? data[63:32] : data[31:0]);
        idle_inputs();
        pc_i = pc;
        #1 chk("idle_arvalid", {63'b0, arvalid_o}, 64'd0);
        tick();
        for (int k = 0; k <= ar_dly; k++) begin
            arready_i = (k == ar_dly);
            #1;
            chk("addr_arvalid", {63'b0, arvalid_o}, 64'd1);
            chk("addr_araddr", araddr_o, {pc[63:3], 3'b000});
            tick();
        end
        arready_i = 1'b0;
        for (int k = 0; k <= r_dly; k++) begin
            rvalid_i = (k == r_dly);
            rdata_i  = (k == r_dly) ? data : {$urandom, $urandom};
            rresp_i  = (k == r_dly) ? resp : 2'b00;
            #1;
            chk("data_rready", {63'b0, rready_o}, 64'd1);
            chk("data_if_valid", {63'b0, if_valid_o}, 64'd0);
            tick();
        end
        rvalid_i = 1'b0;
        rdata_i  = {$urandom, $urandom};
        for (int k = 0; k <= stall; k++) begin
            id_ready_i = (k == stall);
            redirect_i = (k == stall) && hold_redirect;
            #1;
            chk("hold_if_valid", {63'b0, if_valid_o}, 64'd1);
            chk("hold_if_pc", if_pc_o, pc);
            chk("hold_if_inst", {32'b0, if_inst_o}, {32'b0, exp_inst});
            chk("hold_if_fault", {63'b0, if_fault_o}, {63'b0, exp_fault});
            chk("hold_pc_ready", {63'b0, pc_ready_o},
                {63'b0, (k == stall) && !hold_redirect});
            tick();
        end
        idle_inputs();
        #1;
        chk("after_if_valid", {63'b0, if_valid_o}, 64'd0);
        chk("after_pc_ready", {63'b0, pc_ready_o}, 64'd0);
    endtask

    initial begin
        logic [63:0] rpc, rdat;
        logic [1:0]  rrsp;
        reset = 1'b1;
        pc_i  = 64'h0;
        idle_inputs();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_arvalid", {63'b0, arvalid_o}, 64'd0);
        chk("rst_rready", {63'b0, rready_o}, 64'd0);
        chk("rst_if_valid", {63'b0, if_valid_o}, 64'd0);
        chk("rst_if_fault", {63'b0, if_fault_o}, 64'd0);
        chk("rst_pc_ready", {63'b0, pc_ready_o}, 64'd0);
        chk("rst_araddr", araddr_o, 64'h0);
        chk("rst_if_pc", if_pc_o, 64'h0);
        chk("rst_if_inst", {32'b0, if_inst_o}, 64'h0);
        reset = 1'b0;

        // Earliest-latency fetches, low then high word
        do_fetch(64'h8000_0000, 0, 0, 64'h00100093_00000413, 2'b00, 0, 1'b0);
        do_fetch(64'h8000_0004, 0, 0, 64'h00100093_00000413, 2'b00, 0, 1'b0);
        // ID stalls five cycles
        do_fetch(64'h8000_0008, 1, 2, 64'hdeadbeef_cafef00d, 2'b00, 5, 1'b0);

        // Redirect in ADDR with arready three cycles late
        idle_inputs();
        pc_i = 64'h8000_0010;
        tick();
        redirect_i = 1'b1;
        pc_i = 64'h8000_0100;
        #1 chk("kill_araddr_hold", araddr_o, 64'h8000_0010);
        tick();
        redirect_i = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            arready_i = (k == 3);
            #1 chk("kill_araddr_stable", araddr_o, 64'h8000_0010);
            tick();
        end
        arready_i = 1'b0;
        rvalid_i  = 1'b1;
        rdata_i   = 64'h11111111_22222222;
        #1 chk("kill_rready", {63'b0, rready_o}, 64'd1);
        tick();
        rvalid_i = 1'b0;
        #1 chk("kill_no_valid", {63'b0, if_valid_o}, 64'd0);
        do_fetch(64'h8000_0100, 0, 0, 64'h0000006f_00000013, 2'b00, 0, 1'b0);

        // Redirect together with rvalid
        idle_inputs();
        pc_i = 64'h8000_0104;
        tick();
        arready_i = 1'b1;
        tick();
        arready_i  = 1'b0;
        rvalid_i   = 1'b1;
        redirect_i = 1'b1;
        pc_i       = 64'h8000_0200;
        tick();
        idle_inputs();
        #1 chk("rv_redirect_drop", {63'b0, if_valid_o}, 64'd0);
        tick();
        #1 chk("rv_redirect_drop2", {63'b0, if_valid_o}, 64'd0);
        // Now in ADDR for the target; finish it and come back through do_fetch
        chk("rv_redirect_araddr", araddr_o, 64'h8000_0200);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        rvalid_i  = 1'b1;
        tick();
        rvalid_i   = 1'b0;
        id_ready_i = 1'b1;
        #1 chk("rv_redirect_pc", if_pc_o, 64'h8000_0200);
        tick();
        idle_inputs();

        // Redirect wins over id_ready in HOLD
        do_fetch(64'h8000_0300, 0, 0, 64'h12345678_9abcdef0, 2'b00, 1, 1'b1);

        // Error response on the high word
        do_fetch(64'h8000_0404, 0, 1, 64'hffffffff_ffffffff, 2'b10, 0, 1'b0);

        // Asynchronous reset in DATA
        idle_inputs();
        pc_i = 64'h8000_0500;
        tick();
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        #1 chk("pre_rst_rready", {63'b0, rready_o}, 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst_rready", {63'b0, rready_o}, 64'd0);
        chk("async_rst_araddr", araddr_o, 64'h0);
        chk("async_rst_if_pc", if_pc_o, 64'h0);
        chk("async_rst_if_inst", {32'b0, if_inst_o}, 64'h0);
        chk("async_rst_arvalid", {63'b0, arvalid_o}, 64'd0);
        tick();
        reset = 1'b0;
        do_fetch(64'h8000_0000, 0, 0, 64'h00100093_00000413, 2'b00, 0, 1'b0);

        // Randomized fetches
        for (int n = 0; n < 30; n++) begin
            rpc  = 64'h8000_0000 + 64'({$urandom_range(0, 4095), 2'b00});
            rdat = {$urandom, $urandom};
            rrsp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_fetch(rpc, $urandom_range(0, 3), $urandom_range(0, 3), rdat, rrsp,
                     $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
